// File: rtl/fetch_unit_pkg.sv
// Shared widths, the canonical NOP encoding and the fetch-buffer entry layout
// for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry circular queue pairing issued fetch PCs with in-order memory
// responses; entries are allocated at issue, filled on response, popped by decode.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_i,
  input  logic [ILEN-1:0] fill_instr_i,
  input  logic            pop_i,
  output logic            head_valid_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [ILEN-1:0] head_instr_o,
  output logic            full_o,
  output logic [CW-1:0]   unfilled_o
);

  fetch_entry_t   entries_q [DEPTH];
  fetch_entry_t   entries_d [DEPTH];
  logic [PW-1:0]  alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]  fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]  head_ptr_q, head_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  unfilled_q, unfilled_d;
  logic           fill_ok, pop_ok;

  assign head_valid_o = (count_q != '0) && entries_q[head_ptr_q].filled;
  assign head_pc_o    = entries_q[head_ptr_q].pc;
  assign head_instr_o = entries_q[head_ptr_q].instr;
  assign full_o       = (count_q == CW'(DEPTH));
  assign unfilled_o   = unfilled_q;

  // A response with nothing outstanding is a protocol error and is dropped here.
  assign fill_ok = fill_i && (unfilled_q != '0);
  assign pop_ok  = pop_i && head_valid_o;

  always_comb begin
    entries_d   = entries_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    count_d     = count_q;
    unfilled_d  = unfilled_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) entries_d[i].filled = 1'b0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      count_d     = '0;
      unfilled_d  = '0;
    end else begin
      if (alloc_i) begin
        entries_d[alloc_ptr_q].pc     = alloc_pc_i;
        entries_d[alloc_ptr_q].filled = 1'b0;
        alloc_ptr_d = alloc_ptr_q + PW'(1);
      end
      if (fill_ok) begin
        entries_d[fill_ptr_q].instr  = fill_instr_i;
        entries_d[fill_ptr_q].filled = 1'b1;
        fill_ptr_d = fill_ptr_q + PW'(1);
      end
      if (pop_ok) head_ptr_d = head_ptr_q + PW'(1);
      count_d    = count_q + CW'(alloc_i) - CW'(pop_ok);
      unfilled_d = unfilled_q + CW'(alloc_i) - CW'(fill_ok);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      unfilled_q  <= '0;
    end else begin
      entries_q   <= entries_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
      unfilled_q  <= unfilled_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues imem requests at the current PC, drives the
// PC register, and discards responses belonging to redirected-away requests.
module fetch_unit #(
  parameter int XLEN  = fetch_unit_pkg::XLEN,
  parameter int DEPTH = 2,
  parameter int ILEN  = fetch_unit_pkg::ILEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            pc_stall_o,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_rsp_valid_i,
  input  logic [ILEN-1:0] imem_rsp_data_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [ILEN-1:0] if_instr_o,
  input  logic            id_ready_i
);
  import fetch_unit_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(DEPTH * 2) + 1;

  logic [DW-1:0] drop_cnt_q, drop_cnt_d;
  logic [DW:0]   drop_sum;
  logic [CW-1:0] unfilled;
  logic          buf_full, fire, fill, pop;

  assign imem_req_valid_o = !redirect_valid_i && !buf_full && !rst_i;
  assign imem_req_addr_o  = pc_i;
  assign fire = imem_req_valid_o && imem_req_ready_i;
  assign fill = imem_rsp_valid_i && (drop_cnt_q == '0) && !redirect_valid_i;
  assign pop  = if_valid_o && id_ready_i && !redirect_valid_i;

  always_comb begin
    pc_next_o  = pc_i;
    pc_stall_o = 1'b1;
    if (!rst_i) begin
      if (redirect_valid_i) begin
        pc_next_o  = redirect_pc_i;
        pc_stall_o = 1'b0;
      end else if (fire) begin
        pc_next_o  = pc_i + XLEN'(4);
        pc_stall_o = 1'b0;
      end
    end
  end

  // On redirect every outstanding request becomes garbage; a response landing in
  // that same cycle already retires one of them.
  assign drop_sum = {1'b0, drop_cnt_q} + (DW + 1)'(unfilled);

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid_i) begin
      if (imem_rsp_valid_i && (drop_sum != '0)) drop_cnt_d = DW'(drop_sum - (DW + 1)'(1));
      else                                      drop_cnt_d = DW'(drop_sum);
    end else if (imem_rsp_valid_i && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - DW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (redirect_valid_i),
    .alloc_i      (fire),
    .alloc_pc_i   (pc_i),
    .fill_i       (fill),
    .fill_instr_i (imem_rsp_data_i),
    .pop_i        (pop),
    .head_valid_o (if_valid_o),
    .head_pc_o    (if_pc_o),
    .head_instr_o (if_instr_o),
    .full_o       (buf_full),
    .unfilled_o   (unfilled)
  );

  rsp_has_owner: assert property (@(posedge clk_i) disable iff (rst_i)
    imem_rsp_valid_i |-> ((drop_cnt_q != '0) || (unfilled != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level model of the fetch buffer, drop accounting,
// PC register and an in-order fixed-latency instruction memory.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_i, pc_next_o, redirect_pc_i, imem_req_addr_o, if_pc_o;
  logic        pc_stall_o, redirect_valid_i, imem_req_valid_o, imem_req_ready_i;
  logic        imem_rsp_valid_i, if_valid_o, id_ready_i;
  logic [31:0] imem_rsp_data_i, if_instr_o;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(64), .DEPTH(DEPTH), .ILEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .pc_i(pc_i), .pc_next_o(pc_next_o), .pc_stall_o(pc_stall_o),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o),
    .imem_req_ready_i(imem_req_ready_i), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .if_valid_o(if_valid_o), .if_pc_o(if_pc_o),
    .if_instr_o(if_instr_o), .id_ready_i(id_ready_i)
  );

  typedef struct { logic [63:0] pc; logic [31:0] instr; bit filled; } ent_t;
  typedef struct { logic [63:0] addr; int due; } mreq_t;
  typedef logic [226:0] vec_t;

  ent_t  bq[$];
  mreq_t mq[$];
  int    drop, cyc, lat, tests, fails;
  logic [63:0] pc_reg, redir_pc;
  bit    redir, rdy, idr, rspv;
  bit    e_ifv, e_reqv, e_stall;
  logic [63:0] e_pcnext, e_ifpc;
  logic [31:0] e_instr;

  function automatic logic [31:0] instr_of(logic [63:0] a);
    return INSTR_NOP ^ a[31:0] ^ {a[15:0], a[31:16]} ^ a[63:32];
  endfunction

  function automatic vec_t exp_vec();
    return {e_ifv, e_reqv, e_stall, e_pcnext, (e_reqv ? pc_reg : 64'h0), e_ifpc, e_instr};
  endfunction

  function automatic vec_t obs_vec();
    return {if_valid_o, imem_req_valid_o, pc_stall_o, pc_next_o,
            (e_reqv ? imem_req_addr_o : 64'h0),
            (e_ifv ? if_pc_o : 64'h0), (e_ifv ? if_instr_o : 32'h0)};
  endfunction

  // Drive this cycle's inputs and derive what the stage must show.
  task automatic predict();
    rspv = (mq.size() > 0) && (mq[0].due <= cyc);
    pc_i = pc_reg;
    redirect_valid_i = redir;
    redirect_pc_i    = redir_pc;
    imem_req_ready_i = rdy;
    id_ready_i       = idr;
    imem_rsp_valid_i = rspv;
    if (rspv) imem_rsp_data_i = instr_of(mq[0].addr);
    else      imem_rsp_data_i = $urandom();
    e_reqv = !redir && (bq.size() < DEPTH);
    e_ifv  = (bq.size() > 0) && bq[0].filled;
    e_ifpc = e_ifv ? bq[0].pc : 64'h0;
    e_instr = e_ifv ? bq[0].instr : 32'h0;
    if (redir)                begin e_pcnext = redir_pc;     e_stall = 1'b0; end
    else if (e_reqv && rdy)   begin e_pcnext = pc_reg + 64'd4; e_stall = 1'b0; end
    else                      begin e_pcnext = pc_reg;       e_stall = 1'b1; end
  endtask

  // Advance memory, buffer and PC register across the clock edge.
  task automatic commit();
    bit fire;
    ent_t t;
    fire = e_reqv && rdy;
    @(posedge clk);
    if (redir) begin
      bq.delete();
      if (rspv) void'(mq.pop_front());
      drop = mq.size();
    end else begin
      if (rspv) begin
        if (drop > 0) drop--;
        else begin
          for (int k = 0; k < bq.size(); k++) begin
            if (!bq[k].filled) begin
              t = bq[k]; t.instr = instr_of(mq[0].addr); t.filled = 1'b1; bq[k] = t;
              break;
            end
          end
        end
        void'(mq.pop_front());
      end
      if (e_ifv && idr) void'(bq.pop_front());
      if (fire) begin
        bq.push_back('{pc_reg, 32'h0, 1'b0});
        mq.push_back('{pc_reg, cyc + lat});
      end
    end
    if (!e_stall) pc_reg = e_pcnext;
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_reg = 64'h40; pc_i = pc_reg;
    redirect_valid_i = 1'b0; redirect_pc_i = '0; imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0; id_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (if_valid_o !== 1'b0) begin fails++; $display("FAIL reset_if_valid got=%b exp=0", if_valid_o); end
    tests++; if (imem_req_valid_o !== 1'b0) begin fails++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid_o); end
    tests++; if (pc_stall_o !== 1'b1) begin fails++; $display("FAIL reset_pc_stall got=%b exp=1", pc_stall_o); end
    tests++; if (pc_next_o !== 64'h40) begin fails++; $display("FAIL reset_pc_next got=%h exp=40", pc_next_o); end
    tests++; if (if_pc_o !== 64'h0) begin fails++; $display("FAIL reset_if_pc got=%h exp=0", if_pc_o); end
    tests++; if (if_instr_o !== 32'h0) begin fails++; $display("FAIL reset_if_instr got=%h exp=0", if_instr_o); end
    rst = 1'b0; pc_reg = 64'h0; bq.delete(); mq.delete(); drop = 0;
  endtask

  task automatic test_stream();
    logic [63:0] nxt = 64'h0;
    lat = 1; rdy = 1; idr = 1; redir = 0;
    for (int i = 0; i < 24; i++) begin
      predict(); #3;
      tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
      if (i < 2) begin
        tests++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 64'(i * 4)) begin fails++; $display("FAIL stream_req%0d got=%b/%h exp=1/%h", i, imem_req_valid_o, imem_req_addr_o, 64'(i * 4)); end
      end
      if (e_ifv) begin
        tests++; if (if_pc_o !== nxt || if_instr_o !== instr_of(nxt)) begin fails++; $display("FAIL stream_order got=%h/%h exp=%h/%h", if_pc_o, if_instr_o, nxt, instr_of(nxt)); end
        nxt += 64'd4;
      end
      commit();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] hold_pc = '0, nxt;
    logic [31:0] hold_in = '0;
    bit held = 0;
    idr = 0;
    for (int i = 0; i < 5; i++) begin
      predict(); #3;
      tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL stall cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
      if (e_ifv && !held) begin held = 1; hold_pc = if_pc_o; hold_in = if_instr_o; end
      commit();
    end
    predict(); #3;
    tests++; if (imem_req_valid_o !== 1'b0 || pc_stall_o !== 1'b1 || pc_next_o !== pc_reg) begin fails++; $display("FAIL stall_full got=%b/%b/%h exp=0/1/%h", imem_req_valid_o, pc_stall_o, pc_next_o, pc_reg); end
    tests++; if (!held || if_pc_o !== hold_pc || if_instr_o !== hold_in) begin fails++; $display("FAIL stall_stable got=%h/%h exp=%h/%h", if_pc_o, if_instr_o, hold_pc, hold_in); end
    commit();
    idr = 1; nxt = hold_pc;
    for (int i = 0; i < 12; i++) begin
      predict(); #3;
      tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL resume cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
      if (e_ifv) begin
        tests++; if (if_pc_o !== nxt) begin fails++; $display("FAIL resume_order got=%h exp=%h", if_pc_o, nxt); end
        nxt += 64'd4;
      end
      commit();
    end
  endtask

  // Redirect to tgt once the model reports the trigger condition, then wait
  // for the first delivered instruction, which must come from tgt.
  task automatic test_redirect(input string name, input logic [63:0] tgt, input int l, input bit on_rsp);
    bit done = 0, seen = 0;
    lat = l; rdy = 1; idr = 1;
    for (int i = 0; i < 30 && !done; i++) begin
      redir = on_rsp ? ((mq.size() > 0) && (mq[0].due <= cyc)) : (mq.size() >= 2);
      redir_pc = tgt;
      predict(); #3;
      tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL %s_pre cyc=%0d got=%h exp=%h", name, cyc, obs_vec(), exp_vec()); end
      if (redir) begin
        done = 1;
        tests++; if (pc_next_o !== tgt || pc_stall_o !== 1'b0 || imem_req_valid_o !== 1'b0) begin fails++; $display("FAIL %s_cycle got=%h/%b/%b exp=%h/0/0", name, pc_next_o, pc_stall_o, imem_req_valid_o, tgt); end
      end
      commit();
    end
    redir = 0;
    if (!done) begin tests++; fails++; $display("FAIL %s_trigger got=timeout exp=redirect", name); end
    for (int i = 0; i < 30 && !seen; i++) begin
      predict(); #3;
      tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL %s_post cyc=%0d got=%h exp=%h", name, cyc, obs_vec(), exp_vec()); end
      if (if_valid_o === 1'b1) begin
        seen = 1;
        tests++; if (if_pc_o !== tgt || if_instr_o !== instr_of(tgt)) begin fails++; $display("FAIL %s_first got=%h/%h exp=%h/%h", name, if_pc_o, if_instr_o, tgt, instr_of(tgt)); end
      end
      commit();
    end
    if (!seen) begin tests++; fails++; $display("FAIL %s_deliver got=timeout exp=if_valid", name); end
  endtask

  task automatic test_wrap();
    logic [63:0] top = 64'hFFFF_FFFF_FFFF_FFFC;
    logic [63:0] nxt = top;
    lat = 1; rdy = 1; idr = 1;
    redir = 1; redir_pc = top;
    predict(); #3; commit();
    redir = 0;
    predict(); #3;
    tests++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== top || pc_next_o !== 64'h0) begin fails++; $display("FAIL wrap_pc_next got=%b/%h/%h exp=1/%h/0", imem_req_valid_o, imem_req_addr_o, pc_next_o, top); end
    commit();
    for (int i = 0; i < 8; i++) begin
      predict(); #3;
      tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
      if (e_ifv) begin
        tests++; if (if_pc_o !== nxt) begin fails++; $display("FAIL wrap_order got=%h exp=%h", if_pc_o, nxt); end
        nxt += 64'd4;
      end
      commit();
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] held_pc;
    lat = 1; rdy = 1; idr = 1; redir = 0;
    for (int i = 0; i < 6; i++) begin predict(); #3; commit(); end
    predict(); #2;
    rst = 1'b1;
    #1;
    tests++; if (if_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0 || pc_stall_o !== 1'b1) begin fails++; $display("FAIL async_reset got=%b/%b/%b exp=0/0/1", if_valid_o, imem_req_valid_o, pc_stall_o); end
    bq.delete(); mq.delete(); drop = 0;
    held_pc = pc_reg;
    @(posedge clk); #1;
    rst = 1'b0;
    predict(); #3;
    tests++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== held_pc || if_valid_o !== 1'b0) begin fails++; $display("FAIL async_restart got=%b/%h/%b exp=1/%h/0", imem_req_valid_o, imem_req_addr_o, if_valid_o, held_pc); end
    commit();
    for (int i = 0; i < 8; i++) begin
      predict(); #3;
      tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL async_post cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
      commit();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) lat = $urandom_range(1, 3);
      redir = ($urandom_range(0, 19) == 0);
      redir_pc = {$urandom(), $urandom()} & ~64'h3;
      rdy = ($urandom_range(0, 3) != 0);
      idr = ($urandom_range(0, 3) != 0);
      predict(); #3;
      tests++; if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec()); end
      commit();
    end
    redir = 0;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; drop = 0; lat = 1;
    redir = 0; redir_pc = '0; rdy = 1; idr = 1; rspv = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect("redirect", 64'h100, 3, 1'b0);
    test_redirect("collide", 64'h2000, 2, 1'b1);
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
